// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: state codes,
// supported opcodes and datapath mux/ALU encodings.
package mips_pkg;

  localparam int unsigned ANCHO_ESTADO = 4;
  localparam int unsigned ANCHO_OPC    = 6;

  typedef logic [ANCHO_ESTADO-1:0] estado_t;

  localparam estado_t FETCH  = 4'd0;
  localparam estado_t DECODE = 4'd1;
  localparam estado_t MEMADR = 4'd2;
  localparam estado_t MEMRD  = 4'd3;
  localparam estado_t MEMWB  = 4'd4;
  localparam estado_t MEMWR  = 4'd5;
  localparam estado_t EXEC   = 4'd6;
  localparam estado_t RWB    = 4'd7;
  localparam estado_t BRANCH = 4'd8;
  localparam estado_t JUMP   = 4'd9;
  localparam estado_t ADDIEX = 4'd10;
  localparam estado_t ADDIWB = 4'd11;

  localparam logic [ANCHO_OPC-1:0] OP_R    = 6'b000000;
  localparam logic [ANCHO_OPC-1:0] OP_LW   = 6'b100011;
  localparam logic [ANCHO_OPC-1:0] OP_SW   = 6'b101011;
  localparam logic [ANCHO_OPC-1:0] OP_BEQ  = 6'b000100;
  localparam logic [ANCHO_OPC-1:0] OP_J    = 6'b000010;
  localparam logic [ANCHO_OPC-1:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_CUATRO = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCF_ALU    = 2'b00;
  localparam logic [1:0] PCF_ALUOUT = 2'b01;
  localparam logic [1:0] PCF_JUMP   = 2'b10;

  function automatic logic opcode_valido(input logic [ANCHO_OPC-1:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/control_multiciclo.sv
// Moore control FSM for the shared multicycle MIPS datapath, with memory
// wait states and a sticky unsupported-opcode flag.
module control_multiciclo
  import mips_pkg::*;
#(
  parameter int unsigned ANCHO_OP = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ANCHO_OP-1:0] opcode,
  input  logic                cero,
  input  logic                mem_listo,
  output logic                pc_escribe,
  output logic                i_o_d,
  output logic                mem_leer,
  output logic                mem_escribir,
  output logic                ir_escribe,
  output logic                reg_dst,
  output logic                mem_a_reg,
  output logic                reg_escribe,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_fuente,
  output logic                instr_fin,
  output logic                instr_invalida
);

  estado_t             estado;
  estado_t             estado_sig;
  logic [ANCHO_OPC-1:0] op;
  logic                op_ok;

  assign op    = ANCHO_OPC'(opcode);
  assign op_ok = opcode_valido(op);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado         <= FETCH;
      instr_invalida <= 1'b0;
    end else begin
      estado <= estado_sig;
      if (estado == DECODE && !op_ok) instr_invalida <= 1'b1;
    end
  end

  // Next-state: only FETCH, MEMRD and MEMWR look at mem_listo.
  always_comb begin
    estado_sig = FETCH;
    case (estado)
      FETCH:  estado_sig = mem_listo ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_R:          estado_sig = EXEC;
          OP_LW, OP_SW:  estado_sig = MEMADR;
          OP_BEQ:        estado_sig = BRANCH;
          OP_J:          estado_sig = JUMP;
          OP_ADDI:       estado_sig = ADDIEX;
          default:       estado_sig = FETCH;
        endcase
      end
      MEMADR: estado_sig = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  estado_sig = mem_listo ? MEMWB : MEMRD;
      MEMWB:  estado_sig = FETCH;
      MEMWR:  estado_sig = mem_listo ? FETCH : MEMWR;
      EXEC:   estado_sig = RWB;
      RWB:    estado_sig = FETCH;
      BRANCH: estado_sig = FETCH;
      JUMP:   estado_sig = FETCH;
      ADDIEX: estado_sig = ADDIWB;
      ADDIWB: estado_sig = FETCH;
      default: estado_sig = FETCH;
    endcase
  end

  always_comb begin
    pc_escribe   = 1'b0;
    i_o_d        = 1'b0;
    mem_leer     = 1'b0;
    mem_escribir = 1'b0;
    ir_escribe   = 1'b0;
    reg_dst      = 1'b0;
    mem_a_reg    = 1'b0;
    reg_escribe  = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    alu_op       = ALUOP_ADD;
    pc_fuente    = PCF_ALU;
    instr_fin    = 1'b0;
    case (estado)
      FETCH: begin
        mem_leer   = 1'b1;
        alu_src_b  = SRCB_CUATRO;
        ir_escribe = mem_listo;
        pc_escribe = mem_listo;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        instr_fin = !op_ok;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        i_o_d    = 1'b1;
        mem_leer = 1'b1;
      end
      MEMWB: begin
        mem_a_reg   = 1'b1;
        reg_escribe = 1'b1;
        instr_fin   = 1'b1;
      end
      MEMWR: begin
        i_o_d        = 1'b1;
        mem_escribir = 1'b1;
        instr_fin    = mem_listo;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      RWB: begin
        reg_dst     = 1'b1;
        reg_escribe = 1'b1;
        instr_fin   = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_fuente  = PCF_ALUOUT;
        pc_escribe = cero;
        instr_fin  = 1'b1;
      end
      JUMP: begin
        pc_fuente  = PCF_JUMP;
        pc_escribe = 1'b1;
        instr_fin  = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ADDIWB: begin
        reg_escribe = 1'b1;
        instr_fin   = 1'b1;
      end
      default: ;
    endcase
    // State decodes live during reset, so keep every write enable inert.
    if (rst) begin
      pc_escribe   = 1'b0;
      ir_escribe   = 1'b0;
      reg_escribe  = 1'b0;
      mem_escribir = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench: per-cycle vector table with hand-sequenced states, plus
// latency and wait-state sequences.
module tb_control_multiciclo;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MWR = 5;
  localparam int S_EX = 6, S_RWB = 7, S_BR = 8, S_J = 9, S_AE = 10, S_AW = 11;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JJ = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       cero;
    logic       listo;
    int         st;
    logic       inv;
  } vec_t;

  logic clk = 1'b0;
  logic rst, cero, mem_listo;
  logic [5:0] opcode;
  logic pc_escribe, i_o_d, mem_leer, mem_escribir, ir_escribe, reg_dst;
  logic mem_a_reg, reg_escribe, alu_src_a, instr_fin, instr_invalida;
  logic [1:0] alu_src_b, alu_op, pc_fuente;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  control_multiciclo #(.ANCHO_OP(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .cero(cero), .mem_listo(mem_listo),
    .pc_escribe(pc_escribe), .i_o_d(i_o_d), .mem_leer(mem_leer),
    .mem_escribir(mem_escribir), .ir_escribe(ir_escribe), .reg_dst(reg_dst),
    .mem_a_reg(mem_a_reg), .reg_escribe(reg_escribe), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_fuente(pc_fuente),
    .instr_fin(instr_fin), .instr_invalida(instr_invalida)
  );

  function automatic logic [16:0] salidas();
    return {pc_escribe, i_o_d, mem_leer, mem_escribir, ir_escribe, reg_dst,
            mem_a_reg, reg_escribe, alu_src_a, alu_src_b, alu_op, pc_fuente,
            instr_fin, instr_invalida};
  endfunction

  // Output table of each state, written out from the state descriptions.
  function automatic logic [16:0] esperado(input vec_t v);
    logic pc, iod, rd, wr, ir, dst, m2r, we, sa, fin;
    logic [1:0] sb, ao, pf;
    {pc, iod, rd, wr, ir, dst, m2r, we, sa, fin} = '0;
    sb = 2'b00; ao = 2'b00; pf = 2'b00;
    case (v.st)
      S_F:   begin rd = 1; sb = 2'b01; ir = v.listo; pc = v.listo; end
      S_D:   begin sb = 2'b11;
               fin = !(v.op inside {RT, LW, SW, BEQ, JJ, ADDI}); end
      S_MA:  begin sa = 1; sb = 2'b10; end
      S_MR:  begin iod = 1; rd = 1; end
      S_MWB: begin m2r = 1; we = 1; fin = 1; end
      S_MWR: begin iod = 1; wr = 1; fin = v.listo; end
      S_EX:  begin sa = 1; ao = 2'b10; end
      S_RWB: begin dst = 1; we = 1; fin = 1; end
      S_BR:  begin sa = 1; ao = 2'b01; pf = 2'b01; pc = v.cero; fin = 1; end
      S_J:   begin pf = 2'b10; pc = 1; fin = 1; end
      S_AE:  begin sa = 1; sb = 2'b10; end
      S_AW:  begin we = 1; fin = 1; end
      default: ;
    endcase
    if (v.rst) begin pc = 0; ir = 0; we = 0; wr = 0; end
    return {pc, iod, rd, wr, ir, dst, m2r, we, sa, sb, ao, pf, fin, v.inv};
  endfunction

  function automatic vec_t V(input logic r, input logic [5:0] o, input logic c,
                             input logic l, input int s, input logic i);
    vec_t v;
    v.rst = r; v.op = o; v.cero = c; v.listo = l; v.st = s; v.inv = i;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [5:0] o, input logic c,
                       input logic l);
    @(negedge clk);
    rst = r; opcode = o; cero = c; mem_listo = l;
    #2;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction from FETCH until instr_fin; wait_from/wait_len
  // insert low mem_listo cycles starting at the given cycle number.
  task automatic latencia(input string name, input logic [5:0] o,
                          input int wait_from, input int wait_len,
                          input int exp_ciclos, input int exp_wr);
    int ciclos = 0;
    int wr_ciclos = 0;
    logic hecho = 0;
    for (int k = 1; k <= 20 && !hecho; k++) begin
      drive(1'b0, o, 1'b1, !(k >= wait_from && k < wait_from + wait_len));
      ciclos = k;
      if (mem_escribir === 1'b1) wr_ciclos++;
      if (instr_fin === 1'b1) hecho = 1;
    end
    check_int({name, " cycles"}, hecho ? ciclos : -1, exp_ciclos);
    if (exp_wr >= 0) check_int({name, " mem_escribir cycles"}, wr_ciclos, exp_wr);
  endtask

  vec_t tabla[$];

  initial begin
    rst = 1; opcode = '0; cero = 0; mem_listo = 1;
    repeat (2) @(posedge clk);

    tabla.push_back(V(1, LW, 0, 1, S_F, 0));
    // lw, no waits
    tabla.push_back(V(0, LW, 0, 1, S_F, 0));
    tabla.push_back(V(0, LW, 0, 1, S_D, 0));
    tabla.push_back(V(0, LW, 0, 1, S_MA, 0));
    tabla.push_back(V(0, LW, 0, 1, S_MR, 0));
    tabla.push_back(V(0, LW, 0, 1, S_MWB, 0));
    // sw with three wait cycles in MEMWR
    tabla.push_back(V(0, SW, 0, 1, S_F, 0));
    tabla.push_back(V(0, SW, 0, 1, S_D, 0));
    tabla.push_back(V(0, SW, 0, 1, S_MA, 0));
    tabla.push_back(V(0, SW, 0, 0, S_MWR, 0));
    tabla.push_back(V(0, SW, 0, 0, S_MWR, 0));
    tabla.push_back(V(0, SW, 0, 0, S_MWR, 0));
    tabla.push_back(V(0, SW, 0, 1, S_MWR, 0));
    // beq taken, then not taken
    tabla.push_back(V(0, BEQ, 1, 1, S_F, 0));
    tabla.push_back(V(0, BEQ, 1, 1, S_D, 0));
    tabla.push_back(V(0, BEQ, 1, 1, S_BR, 0));
    tabla.push_back(V(0, BEQ, 0, 1, S_F, 0));
    tabla.push_back(V(0, BEQ, 0, 1, S_D, 0));
    tabla.push_back(V(0, BEQ, 0, 1, S_BR, 0));
    // R-type (mem_listo low where it must be ignored), then j
    tabla.push_back(V(0, RT, 0, 1, S_F, 0));
    tabla.push_back(V(0, RT, 0, 0, S_D, 0));
    tabla.push_back(V(0, RT, 0, 0, S_EX, 0));
    tabla.push_back(V(0, RT, 0, 0, S_RWB, 0));
    tabla.push_back(V(0, JJ, 0, 1, S_F, 0));
    tabla.push_back(V(0, JJ, 0, 1, S_D, 0));
    tabla.push_back(V(0, JJ, 0, 1, S_J, 0));
    // fetch wait states, then unsupported opcode
    tabla.push_back(V(0, BAD, 0, 0, S_F, 0));
    tabla.push_back(V(0, BAD, 0, 0, S_F, 0));
    tabla.push_back(V(0, BAD, 0, 1, S_F, 0));
    tabla.push_back(V(0, BAD, 0, 1, S_D, 0));
    // addi with sticky flag set
    tabla.push_back(V(0, ADDI, 0, 1, S_F, 1));
    tabla.push_back(V(0, ADDI, 0, 1, S_D, 1));
    tabla.push_back(V(0, ADDI, 0, 1, S_AE, 1));
    tabla.push_back(V(0, ADDI, 0, 1, S_AW, 1));
    // reset in the middle of MEMRD, held two cycles
    tabla.push_back(V(0, LW, 0, 1, S_F, 1));
    tabla.push_back(V(0, LW, 0, 1, S_D, 1));
    tabla.push_back(V(0, LW, 0, 1, S_MA, 1));
    tabla.push_back(V(0, LW, 0, 0, S_MR, 1));
    tabla.push_back(V(1, LW, 0, 1, S_MR, 1));
    tabla.push_back(V(1, LW, 0, 1, S_F, 0));
    tabla.push_back(V(0, LW, 0, 1, S_F, 0));
    tabla.push_back(V(0, LW, 0, 1, S_D, 0));
    tabla.push_back(V(0, LW, 0, 1, S_MA, 0));
    tabla.push_back(V(0, LW, 0, 1, S_MR, 0));
    tabla.push_back(V(0, LW, 0, 1, S_MWB, 0));

    foreach (tabla[i]) begin
      logic [16:0] exp_v, act_v;
      drive(tabla[i].rst, tabla[i].op, tabla[i].cero, tabla[i].listo);
      exp_v = esperado(tabla[i]);
      act_v = salidas();
      n_vec++;
      if (act_v !== exp_v || (mem_leer === 1'b1 && mem_escribir === 1'b1)) begin
        n_err++;
        $display("FAIL vec%0d (state %0d): outputs %b, expected %b",
                 i, tabla[i].st, act_v, exp_v);
      end
    end

    latencia("lw",  LW,   0, 0, 5, -1);
    latencia("sw",  SW,   0, 0, 4, 1);
    latencia("R",   RT,   0, 0, 4, -1);
    latencia("addi", ADDI, 0, 0, 4, -1);
    latencia("beq", BEQ,  0, 0, 3, -1);
    latencia("j",   JJ,   0, 0, 3, -1);
    latencia("sw_wait", SW, 4, 3, 7, 4);
    latencia("lw_fetch_wait", LW, 1, 2, 7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Moore-style control FSM that sequences the shared multicycle MIPS datapath (single memory, single ALU, IR/A/B/ALUOut registers) through fetch, decode, execute, memory and write-back. It decodes the instruction opcode and drives every datapath enable and mux select. It also inserts wait states on a memory-ready handshake and flags unsupported opcodes. It sits inside `MIPS`, beside the datapath, and replaces the single-cycle combinational control.

## Interface
Parameters:
- `ANCHO_OP`, 6, opcode width; fixed by ISA, exposed only for lint.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `cero`  in  1  ALU zero flag, used in BRANCH.
- `mem_listo`  in  1  memory completed the current access this cycle.
- `pc_escribe`  out  1  PC load enable (already includes branch condition).
- `i_o_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_leer` / `mem_escribir`  out  1 each  memory strobes.
- `ir_escribe`  out  1  IR load enable.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_a_reg`  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- `reg_escribe`  out  1  register-file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = signext(imm), 11 = signext(imm)<<2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = use funct.
- `pc_fuente`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_fin`  out  1  one-cycle pulse on the last cycle of each instruction.
- `instr_invalida`  out  1  sticky flag for an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- FETCH:
  - Outputs: i_o_d=0, mem_leer=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_fuente=00.
  - ir_escribe and pc_escribe are asserted only when mem_leer=1 and mem_listo=1.
  - Stay in FETCH while mem_listo=0; go to DECODE when mem_listo=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDIEX.
  - Any other opcode → FETCH, sets instr_invalida and pulses instr_fin.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEMRD, sw → MEMWR.
- MEMRD: i_o_d=1, mem_leer=1. Hold until mem_listo=1, then → MEMWB.
- MEMWB: reg_dst=0, mem_a_reg=1, reg_escribe=1, instr_fin=1 → FETCH.
- MEMWR: i_o_d=1, mem_escribir=1. Hold until mem_listo=1, then instr_fin=1 → FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → RWB.
- RWB: reg_dst=1, mem_a_reg=0, reg_escribe=1, instr_fin=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_fuente=01, pc_escribe=cero, instr_fin=1 → FETCH.
- JUMP: pc_fuente=10, pc_escribe=1, instr_fin=1 → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDIWB.
- ADDIWB: reg_dst=0, mem_a_reg=0, reg_escribe=1, instr_fin=1 → FETCH.
- Every output not listed for a state is 0.
- mem_leer and mem_escribir are never asserted together.
- The strobe stays asserted for the whole wait period.

## Timing
- State register updates on the clock edge. Outputs are combinational from state; pc_escribe and ir_escribe also depend on mem_listo/cero.
- On rst=1 at an edge: state=FETCH and instr_invalida=0. This applies mid-instruction too; no partial write completes after that edge.
- Because FETCH decoding is live during reset, all enables are inert while rst=1: pc_escribe, ir_escribe, reg_escribe and mem_escribir are forced to 0.
- Latency with mem_listo held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Each low cycle of mem_listo adds one cycle in FETCH, MEMRD or MEMWR.
- mem_listo is ignored in all other states.
- instr_invalida clears only on rst.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum;
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - encodings for alu_src_b, alu_op and pc_fuente.
- Single module with no sub-module: a next-state always block plus an output-decode always block.

## Test plan
- Reset: hold rst=1 for 2 cycles, including mid-MEMRD → state FETCH, mem_leer=1, pc_escribe=0, instr_invalida=0.
- lw (opcode 100011), mem_listo=1 → visits FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_escribe=1 only in cycle 5; instr_fin pulses once.
- sw with mem_listo low for 3 cycles in MEMWR → mem_escribir high for 4 consecutive cycles; total 7 cycles.
- beq with cero=1 → pc_escribe=1, pc_fuente=01 in cycle 3. With cero=0 → pc_escribe=0 and FETCH follows.
- R-type then j back-to-back → 4 + 3 cycles; JUMP has pc_fuente=10 and pc_escribe=1.
- opcode 111111 → DECODE returns to FETCH; instr_invalida=1 and stays set through a following addi (4 cycles).
